// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: array or shift-add multiply, radix-2
// restoring divide, with divide-by-zero/overflow early-out and flush.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_ITER = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result,
    output logic [1:0]      state_dbg
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   a_mag_q, a_mag_d;
    logic [XLEN-1:0]   b_mag_q, b_mag_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Handshake: start is taken only in IDLE/DONE with flush low (accept);
    // busy is accept OR an operation in flight; valid is a one-cycle strobe
    // in DONE and result holds its value until the next valid.
    logic accept;
    assign accept = reset & start & ~flush & (state_q == S_IDLE || state_q == S_DONE);

    logic            is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
    logic            div_zero_in, ovf_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in, special_res;

    always_comb begin
        is_div_in   = op[2];
        a_sgn_in    = is_div_in ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        b_sgn_in    = is_div_in ? ~op[0] : (op[1:0] == 2'b01);
        a_neg_in    = a_sgn_in & src_a[XLEN-1];
        b_neg_in    = b_sgn_in & src_b[XLEN-1];
        a_mag_in    = a_neg_in ? -src_a : src_a;
        b_mag_in    = b_neg_in ? -src_b : src_b;
        div_zero_in = (src_b == '0);
        ovf_in      = ~op[0] & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (&src_b);
        if (div_zero_in) begin
            special_res = op[1] ? src_a : '1;
        end else begin
            special_res = op[1] ? '0 : src_a;
        end
    end

    logic [XLEN:0]     msum, dshift, ddiff;
    logic              dq;
    logic [2*XLEN-1:0] mul_next, div_next, prod_arr, prod_src, prod_sgn;
    logic [XLEN-1:0]   quo, rem, mul_res, div_res;

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        msum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_mag_q & {XLEN{acc_q[0]}}};
        mul_next = {msum, acc_q[XLEN-1:1]};
        dshift   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        ddiff    = dshift - {1'b0, b_mag_q};
        dq       = ~ddiff[XLEN];
        div_next = {(dq ? ddiff[XLEN-1:0] : dshift[XLEN-1:0]), acc_q[XLEN-2:0], dq};
        prod_arr = {{XLEN{1'b0}}, a_mag_q} * {{XLEN{1'b0}}, b_mag_q};
        prod_src = (MUL_ITER != 0) ? mul_next : prod_arr;
        prod_sgn = neg_q ? -prod_src : prod_src;
        mul_res  = (op_q == 2'b00) ? prod_sgn[XLEN-1:0] : prod_sgn[2*XLEN-1:XLEN];
        quo      = div_next[XLEN-1:0];
        rem      = div_next[2*XLEN-1:XLEN];
        div_res  = op_q[1] ? (rneg_q ? -rem : rem) : (neg_q ? -quo : quo);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (accept) begin
                        op_d    = op[1:0];
                        a_mag_d = a_mag_in;
                        b_mag_d = b_mag_in;
                        neg_d   = a_neg_in ^ b_neg_in;
                        rneg_d  = a_neg_in;
                        cnt_d   = CW'(XLEN);
                        if (is_div_in & (div_zero_in | ovf_in)) begin
                            result_d = special_res;
                            state_d  = S_DONE;
                        end else if (is_div_in) begin
                            acc_d   = {{XLEN{1'b0}}, a_mag_in};
                            state_d = S_DIV;
                        end else begin
                            acc_d   = {{XLEN{1'b0}}, b_mag_in};
                            state_d = S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc_d = mul_next;
                    cnt_d = cnt_q - CW'(1);
                    if (MUL_ITER == 0 || cnt_q == CW'(1)) begin
                        result_d = mul_res;
                        state_d  = S_DONE;
                    end
                end
                S_DIV: begin
                    acc_d = div_next;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_d = div_res;
                        state_d  = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy      = accept | (state_q == S_MUL) | (state_q == S_DIV);
    assign valid     = (state_q == S_DONE);
    assign result    = result_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit array-multiply instance and a
// 16-bit shift-add instance, checked against plain-arithmetic reference.
`timescale 1ns/1ps
module tb_muldiv_unit;
    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        a_rst, a_start, a_flush, a_busy, a_valid;
    logic [2:0]  a_op;
    logic [31:0] a_sa, a_sb, a_result;
    logic [1:0]  a_state;
    logic        b_rst, b_start, b_flush, b_busy, b_valid;
    logic [2:0]  b_op;
    logic [15:0] b_sa, b_sb, b_result;
    logic [1:0]  b_state;

    muldiv_unit #(.XLEN(32), .MUL_ITER(0)) dut_a (
        .clk(clk), .reset(a_rst), .start(a_start), .op(a_op), .src_a(a_sa), .src_b(a_sb),
        .flush(a_flush), .busy(a_busy), .valid(a_valid), .result(a_result), .state_dbg(a_state)
    );

    muldiv_unit #(.XLEN(16), .MUL_ITER(1)) dut_b (
        .clk(clk), .reset(b_rst), .start(b_start), .op(b_op), .src_a(b_sa), .src_b(b_sb),
        .flush(b_flush), .busy(b_busy), .valid(b_valid), .result(b_result), .state_dbg(b_state)
    );

    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];
    int          cyc_q_a[$];
    int          cyc_q_b[$];
    logic [31:0] last_res_a = '0;
    logic [31:0] last_res_b = '0;

    function automatic logic [31:0] model(input int xl, input logic [2:0] op,
                                          input logic [31:0] x, input logic [31:0] y);
        longint m, ua, ub, sa, sb, minv, r;
        m    = (longint'(1) << xl) - 1;
        ua   = longint'(x) & m;
        ub   = longint'(y) & m;
        minv = -(longint'(1) << (xl - 1));
        sa   = (ua > (m >> 1)) ? ua - (m + 1) : ua;
        sb   = (ub > (m >> 1)) ? ub - (m + 1) : ub;
        case (op)
            3'd0:    r = ua * ub;
            3'd1:    r = (sa * sb) >> xl;
            3'd2:    r = (sa * ub) >> xl;
            3'd3:    r = (ua * ub) >> xl;
            3'd4:    r = (ub == 0) ? m : ((sa == minv && sb == -1) ? ua : sa / sb);
            3'd5:    r = (ub == 0) ? m : ua / ub;
            3'd6:    r = (ub == 0) ? ua : ((sa == minv && sb == -1) ? 0 : sa % sb);
            default: r = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(r & m);
    endfunction

    // Cycles from the start cycle to the valid cycle.
    function automatic int lat(input int xl, input bit iter, input logic [2:0] op,
                               input logic [31:0] x, input logic [31:0] y);
        longint m;
        bit     zero, ovf;
        m    = (longint'(1) << xl) - 1;
        zero = ((longint'(y) & m) == 0);
        ovf  = !op[0] && ((longint'(x) & m) == (longint'(1) << (xl - 1))) && ((longint'(y) & m) == m);
        if (op[2]) return (zero || ovf) ? 1 : xl + 1;
        return iter ? xl + 1 : 2;
    endfunction

    function automatic logic [31:0] pick(input int xl);
        logic [31:0] mask;
        mask = (xl == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return mask;
            2:       return 32'h1 << (xl - 1);
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom() & mask;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon_a
        logic [31:0] e;
        int          c;
        if (a_valid === 1'b1) begin
            if (exp_q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_valid: got valid=1 at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q_a.pop_front();
                c = cyc_q_a.pop_front();
                chk("a_result", a_result, e);
                chk("a_latency", cyc, c);
                last_res_a = e;
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [31:0] e;
        int          c;
        if (b_valid === 1'b1) begin
            if (exp_q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_valid: got valid=1 at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q_b.pop_front();
                c = cyc_q_b.pop_front();
                chk("b_result", {16'h0, b_result}, e);
                chk("b_latency", cyc, c);
                last_res_b = e;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start for one cycle; ends one cycle later with start low.
    task automatic issue(input bit sel, input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, input bit push);
        if (!sel) begin
            a_start = 1'b1; a_op = op; a_sa = x; a_sb = y;
            if (push) begin
                exp_q_a.push_back(model(32, op, x, y));
                cyc_q_a.push_back(cyc + lat(32, 1'b0, op, x, y));
            end
            #1;
            chk("a_busy_accept", {31'h0, a_busy}, 32'h1);
        end else begin
            b_start = 1'b1; b_op = op; b_sa = x[15:0]; b_sb = y[15:0];
            if (push) begin
                exp_q_b.push_back(model(16, op, x & 32'hFFFF, y & 32'hFFFF));
                cyc_q_b.push_back(cyc + lat(16, 1'b1, op, x & 32'hFFFF, y & 32'hFFFF));
            end
            #1;
            chk("b_busy_accept", {31'h0, b_busy}, 32'h1);
        end
        tick();
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic wait_valid(input bit sel);
        int n;
        n = 0;
        while (((sel ? b_valid : a_valid) !== 1'b1) && n < 100) begin
            tick();
            n++;
        end
        if ((sel ? b_valid : a_valid) !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no valid in 100 cycles, expected a valid", sel ? "b" : "a");
        end
    endtask

    task automatic run(input bit sel, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        issue(sel, op, x, y, 1'b1);
        wait_valid(sel);
        tick();
    endtask

    initial begin
        a_rst = 1'b0; a_start = 1'b0; a_flush = 1'b0; a_op = '0; a_sa = '0; a_sb = '0;
        b_rst = 1'b0; b_start = 1'b0; b_flush = 1'b0; b_op = '0; b_sa = '0; b_sb = '0;
        repeat (3) tick();
        chk("a_reset_valid", {31'h0, a_valid}, 32'h0);
        chk("a_reset_result", a_result, 32'h0);
        chk("a_reset_busy", {31'h0, a_busy}, 32'h0);
        chk("b_reset_valid", {31'h0, b_valid}, 32'h0);
        chk("b_reset_result", {16'h0, b_result}, 32'h0);
        a_rst = 1'b1;
        b_rst = 1'b1;
        tick();

        // Array multiply, busy only in the start cycle and the MUL cycle.
        issue(1'b0, 3'b000, 32'h7, 32'hFFFF_FFFD, 1'b1);
        #1;
        chk("a_busy_mul_cycle", {31'h0, a_busy}, 32'h1);
        wait_valid(1'b0);
        chk("a_busy_done", {31'h0, a_busy}, 32'h0);
        tick();
        run(1'b0, 3'b001, 32'h8000_0000, 32'h8000_0000);
        run(1'b0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Signed divide then remainder started in the DONE cycle.
        issue(1'b0, 3'b100, 32'hFFFF_FFF9, 32'h2, 1'b1);
        wait_valid(1'b0);
        issue(1'b0, 3'b110, 32'hFFFF_FFF9, 32'h2, 1'b1);
        wait_valid(1'b0);
        tick();

        run(1'b0, 3'b101, 32'h5, 32'h0);
        run(1'b0, 3'b110, 32'h5, 32'h0);
        run(1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        run(1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        run(1'b0, 3'b100, 32'h5, 32'h0);

        // Flush mid-divide at N+10.
        issue(1'b0, 3'b101, 32'd1000, 32'd3, 1'b0);
        repeat (9) tick();
        a_flush = 1'b1;
        #1;
        chk("a_busy_before_flush", {31'h0, a_busy}, 32'h1);
        tick();
        a_flush = 1'b0;
        #1;
        chk("a_busy_after_flush", {31'h0, a_busy}, 32'h0);
        chk("a_valid_after_flush", {31'h0, a_valid}, 32'h0);
        chk("a_result_held", a_result, last_res_a);
        run(1'b0, 3'b000, 32'd3, 32'd4);
        a_start = 1'b1; a_flush = 1'b1; a_op = 3'b000; a_sa = 32'd5; a_sb = 32'd5;
        #1;
        chk("a_busy_start_flush", {31'h0, a_busy}, 32'h0);
        tick();
        a_start = 1'b0;
        a_flush = 1'b0;
        #1;
        chk("a_busy_not_accepted", {31'h0, a_busy}, 32'h0);
        chk("a_valid_not_accepted", {31'h0, a_valid}, 32'h0);
        repeat (3) tick();

        // Reset in the middle of a divide.
        issue(1'b0, 3'b100, 32'hFFFF_FF00, 32'd7, 1'b0);
        repeat (4) tick();
        a_rst = 1'b0;
        #1;
        chk("a_midreset_valid", {31'h0, a_valid}, 32'h0);
        chk("a_midreset_result", a_result, 32'h0);
        chk("a_midreset_busy", {31'h0, a_busy}, 32'h0);
        last_res_a = '0;
        repeat (2) tick();
        a_rst = 1'b1;
        tick();
        run(1'b0, 3'b101, 32'd100, 32'd7);

        for (int i = 0; i < 40; i++) begin
            issue(1'b0, 3'($urandom_range(0, 7)), pick(32), pick(32), 1'b1);
            wait_valid(1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();

        // Shift-add instance.
        run(1'b1, 3'b011, 32'hFFFF, 32'hFFFF);
        run(1'b1, 3'b000, 32'h0100, 32'h0100);
        run(1'b1, 3'b101, 32'd100, 32'd7);
        run(1'b1, 3'b111, 32'd100, 32'd7);
        run(1'b1, 3'b001, 32'h8000, 32'h8000);
        run(1'b1, 3'b010, 32'hFFFF, 32'hFFFF);
        run(1'b1, 3'b100, 32'h8000, 32'hFFFF);
        run(1'b1, 3'b110, 32'hFFF9, 32'h2);
        run(1'b1, 3'b111, 32'h5, 32'h0);
        for (int i = 0; i < 30; i++) begin
            issue(1'b1, 3'($urandom_range(0, 7)), pick(16), pick(16), 1'b1);
            wait_valid(1'b1);
            if ($urandom_range(0, 1) == 1) tick();
        end

        repeat (5) tick();
        chk("a_queue_drained", 32'(exp_q_a.size()), 32'h0);
        chk("b_queue_drained", 32'(exp_q_b.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative M-extension unit for the next-generation core.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on XLEN-bit operands.
- Sits in the execute stage beside the integer ALU.
- The hazard unit stalls F/D/E on `busy` and completes the instruction on `valid`.
- Width and multiplier architecture are configurable. Flush and early-out of RISC-V special cases are built in.

Parameters:
XLEN, 32, operand and result width; legal values are 16, 32 or 64.
MUL_ITER, 0, multiplier architecture: 0 = single-stage array multiply; 1 = shift-add, one bit per cycle.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request; operands and op are valid this cycle.
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
src_a  input  XLEN  rs1 operand (multiplicand or dividend).
src_b  input  XLEN  rs2 operand (multiplier or divisor).
flush  input  1  synchronous kill of the in-flight or requesting operation.
busy  output  1  stall request to the hazard unit.
valid  output  1  one-cycle result-ready strobe.
result  output  XLEN  final result; held until the next valid.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - valid=0, result=0, iteration counter=0, operand/accumulator registers=0.
  - busy=0 whenever start=0.
- States:
  - IDLE.
  - MUL: one cycle if MUL_ITER=0, XLEN cycles if MUL_ITER=1.
  - DIV: XLEN cycles, radix-2 restoring.
  - DONE: one cycle.
- Accept condition: start=1 and flush=0 while in IDLE or DONE. Start in DONE gives back-to-back operation.
  - On accept, src_a, src_b and op are captured.
  - Operand magnitudes and result sign are computed at capture.
  - start in any other state is ignored.
- busy (combinational):
  - busy = (accept condition true) OR (state is MUL or DIV).
  - busy=0 in DONE, so the pipeline advances in the same cycle valid is high.
- Latency, with the accept edge at cycle N:
  - MUL_ITER=0 multiplies: valid at N+2.
  - MUL_ITER=1 multiplies: valid at N+XLEN+1.
  - Divides: valid at N+XLEN+1.
  - Special cases skip MUL/DIV and go straight to DONE: valid at N+1.
- Special cases (resolved at accept):
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return the dividend.
  - Signed overflow (DIV/REM with src_a = -2^(XLEN-1), src_b = -1): DIV returns the dividend; REM returns 0.
- Arithmetic:
  - Full 2*XLEN-bit product.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half, with operand signedness per funct3.
  - Quotient is negated when the operand signs differ (signed ops only).
  - Remainder takes the dividend's sign.
  - Counter width is clog2(XLEN)+1 bits.
- Flush:
  - In any state, flush=1 returns the block to IDLE at the next edge.
  - No valid is produced and result is unchanged.
  - flush together with start: flush wins and nothing is accepted. busy=0 that cycle unless the state is MUL or DIV.
- DONE always returns to IDLE (or to MUL/DIV if a new start is accepted).
- Reset mid-operation aborts immediately and gives the reset values.
- Reset and flush override start; there is no hold-off.

Test Plan:
1. XLEN=32, MUL_ITER=0. MUL 7 × 0xFFFFFFFD -> result 0xFFFFFFEB, valid at N+2, busy high in cycles N and N+1 only. Then MULH 0x80000000 × 0x80000000 -> 0x40000000. Then MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF. Then MULHU on the same operands -> 0xFFFFFFFE.
2. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, valid at N+33. REM on the same operands -> 0xFFFFFFFF. The REM start is issued in the DONE cycle of the DIV and must be accepted back-to-back.
3. Special cases, each with valid at N+1:
   - DIVU 5/0 -> 0xFFFFFFFF.
   - REM 5/0 -> 5.
   - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
   - REM 0x80000000 / 0xFFFFFFFF -> 0.
4. DIVU started, flush asserted at N+10:
   - No valid pulse.
   - busy low from N+11.
   - result keeps its previous value.
   - A new MUL 3×4 at N+11 returns 12.
   - start and flush in the same cycle: not accepted, busy=0.
5. reset driven low at N+5 of a DIV: valid=0, result=0, busy=0 asynchronously. After release, DIVU 100/7 returns 14.
6. XLEN=16, MUL_ITER=1:
   - MULU-high (MULHU) 0xFFFF × 0xFFFF -> 0xFFFE, valid at N+17.
   - MUL 0x0100 × 0x0100 -> 0x0000.
   - DIVU 100/7 -> 14, and REMU -> 2, valid at N+17.
